// File: rtl/bridge_pkg.sv
// Shared address map, CTRL layout, MODE codes and timer state encoding for the
// MEM-stage data bridge and its timer.
package bridge_pkg;

  localparam logic [31:0] DM_BASE  = 32'h0000_0000;
  localparam logic [31:0] DM_LIMIT = 32'h0000_2FFF;
  localparam logic [31:0] TMR_BASE = 32'h0000_7F00;

  // Word index of each timer register (address bits [3:2])
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM       = 3;
  localparam int CTRL_W        = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } tmr_state_e;

  // Offset form keeps the check valid for any DM_BASE, including zero
  function automatic logic dm_hit(input logic [31:0] addr);
    return (addr - DM_BASE) <= (DM_LIMIT - DM_BASE);
  endfunction

  function automatic logic tmr_hit(input logic [31:0] addr);
    return (addr[31:4] == TMR_BASE[31:4]) && (addr[3:2] != 2'b11);
  endfunction

endpackage

// File: rtl/data_bridge_timer_core.sv
// Preset-countdown timer: CTRL/PRESET/COUNT registers, the IDLE/LOAD/CNT/INT
// sequencer and the registered interrupt line.
module timer_core
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d, ctrl_fsm_s;
  logic [31:0]       preset_q, preset_d;
  logic [31:0]       count_q, count_d;
  tmr_state_e        state_q, state_d;
  logic              irq_flag_q, irq_flag_d, irq_flag_fsm_s, irq_set_s;
  logic              irq_q, irq_d;
  logic              ctrl_wr_s, preset_wr_s;

  assign ctrl_wr_s   = we && (reg_sel == REG_CTRL);
  assign preset_wr_s = we && (reg_sel == REG_PRESET);

  // Sequencer reacts to the pre-write CTRL value; a CPU CTRL write then overrides it
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    ctrl_fsm_s     = ctrl_q;
    irq_flag_fsm_s = irq_flag_q;
    irq_set_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_q[CTRL_EN]) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[CTRL_EN]) begin
          state_d = IDLE;
        end else if (count_q == 32'd0) begin
          state_d   = INT;
          irq_set_s = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
          state_d = CNT;
        end
      end
      INT: begin
        state_d = IDLE;
        case (ctrl_q[CTRL_MODE_LSB +: 2])
          MODE_ONESHOT: ctrl_fsm_s[CTRL_EN] = 1'b0;
          MODE_RELOAD:  irq_flag_fsm_s      = 1'b0;
          default:      ctrl_fsm_s[CTRL_EN] = 1'b0;
        endcase
      end
      default: state_d = IDLE;
    endcase

    ctrl_d     = ctrl_wr_s ? wdata[CTRL_W-1:0] : ctrl_fsm_s;
    preset_d   = preset_wr_s ? wdata : preset_q;
    // An expiry in the same cycle as a CTRL write is not lost
    irq_flag_d = irq_set_s | (irq_flag_fsm_s & ~ctrl_wr_s);
    irq_d      = irq_flag_d & ctrl_d[CTRL_IM];
  end

  // Timer register state and the registered irq output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q     <= '0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      state_q    <= IDLE;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      state_q    <= state_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_d;
    end
  end

  // Register read mux; address bits [1:0] are not looked at
  always_comb begin
    case (reg_sel)
      REG_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
      REG_PRESET: rdata = preset_q;
      REG_COUNT:  rdata = count_q;
      default:    rdata = 32'd0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: rtl/data_bridge.sv
// MEM-stage data bridge: decodes DM / timer / unmapped accesses and muxes load data.
// Define BRIDGE_TIMER_EN to include the timer; otherwise its range is unmapped and irq is 0.
module data_bridge
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  output logic [31:0] cpu_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_byteen,
  input  logic [31:0] dm_rdata,
  output logic        irq,
  output logic        addr_err
);

  logic        dm_hit_s;
  logic        tmr_hit_s;
  logic [31:0] tmr_rdata_s;

  assign dm_hit_s = dm_hit(cpu_addr);

`ifdef BRIDGE_TIMER_EN
  logic tmr_we_s;

  assign tmr_hit_s = tmr_hit(cpu_addr);
  // Only full-word stores reach the timer
  assign tmr_we_s  = tmr_hit_s && (cpu_byteen == 4'hF);

  timer_core u_timer (
    .clk     (clk),
    .reset   (reset),
    .we      (tmr_we_s),
    .reg_sel (cpu_addr[3:2]),
    .wdata   (cpu_wdata),
    .rdata   (tmr_rdata_s),
    .irq     (irq)
  );
`else
  logic irq_q;

  assign tmr_hit_s   = 1'b0;
  assign tmr_rdata_s = 32'd0;

  // irq keeps its registered form but never leaves zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`endif

  assign dm_addr   = cpu_addr;
  assign dm_wdata  = cpu_wdata;
  assign dm_byteen = dm_hit_s ? cpu_byteen : 4'h0;
  assign addr_err  = !(dm_hit_s || tmr_hit_s);

  // Same-cycle load data: the core captures it at the next edge
  always_comb begin
    if (dm_hit_s) begin
      cpu_rdata = dm_rdata;
    end else if (tmr_hit_s) begin
      cpu_rdata = tmr_rdata_s;
    end else begin
      cpu_rdata = 32'd0;
    end
  end

endmodule
